// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO between the UART receiver and a valid/ready consumer, with level,
// almost-full and sticky overflow. Define UART_RX_FIFO_TIMEOUT_EN to add the idle timeout.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = 12,
  parameter int IDLE_CYCLES  = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       uart_rx_valid,
  input  logic [PAYLOAD_BITS-1:0]    uart_rx_data,
  input  logic                       uart_rx_break,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [PAYLOAD_BITS-1:0]    m_data,
  output logic                       m_break,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       almost_full,
  output logic                       overflow,
  input  logic                       overflow_clr,
  output logic                       rx_idle
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AFULL_LEVEL < 1 ||
      AFULL_LEVEL > DEPTH || IDLE_CYCLES < 1) begin : g_bad_params
    $error("uart_rx_fifo: illegal parameter combination");
  end

  logic [PAYLOAD_BITS:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level_q;
  logic [LVL_W-1:0]      level_d;
  logic [PAYLOAD_BITS:0] head;
  logic                  push;
  logic                  pop;
  logic                  drop;

  assign m_valid = (level_q != '0);
  assign pop     = m_valid && m_ready;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push    = uart_rx_valid && ((level_q != LVL_W'(DEPTH)) || pop);
  assign drop    = uart_rx_valid && !push;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_d;
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // Storage carries data only, so it is left out of reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {uart_rx_break, uart_rx_data};
  end

  assign head        = mem[rd_ptr];
  assign m_data      = m_valid ? head[PAYLOAD_BITS-1:0] : '0;
  assign m_break     = m_valid ? head[PAYLOAD_BITS] : 1'b0;
  assign level       = level_q;
  assign almost_full = (level_q >= LVL_W'(AFULL_LEVEL));

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;

  always_ff @(posedge clk) begin
    if (reset || push || (level_q == '0))
      idle_cnt <= '0;
    else if (idle_cnt != IDLE_W'(IDLE_CYCLES))
      idle_cnt <= idle_cnt + 1'b1;
  end

  assign rx_idle = (idle_cnt == IDLE_W'(IDLE_CYCLES)) && m_valid;
`else
  assign rx_idle = 1'b0;
`endif

endmodule
